save_slot_store: RTL

Storage responder for the save/load menu. It consumes the slot-select codes and sensor snapshot driven by the VGA menu controller, and commits a snapshot into one of three slots once a save code has been held stable. On a stable load code it returns the stored snapshot on `sensor_output`. The block sits between the VGA menu controller and the game logic, in the VGA clock domain.

---
 rtl/save_slot_pkg.sv | 17 +
 rtl/save_slot_store_code_settle.sv | 79 +++++++
 rtl/save_slot_store.sv | 115 +++++++++++
 3 files changed

// File: rtl/save_slot_pkg.sv
// Shared slot codes, FSM states and operation type for the save/load slot store.
package save_slot_pkg;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOC1 = 2'd1;
  localparam logic [1:0] LOC2 = 2'd2;
  localparam logic [1:0] LOC3 = 2'd3;

  typedef enum logic [2:0] {IDLE, SETTLE, SAVE, LOAD, HOLD} state_t;
  typedef enum logic {OP_SAVE, OP_LOAD} op_t;

  // Anything outside 1..3 on the 32-bit menu bus is treated as no request.
  function automatic logic [1:0] slot_code(input logic [31:0] raw);
    return (raw <= 32'd3) ? raw[1:0] : NONE;
  endfunction

endpackage

// File: rtl/save_slot_store_code_settle.sv
// Input register plus latched-code tracking and settle counter for save_slot_store.
import save_slot_pkg::*;

module code_settle #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DATA_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       save_signal,
  input  logic [31:0]       load_signal,
  input  logic [DATA_W-1:0] data_in,
  input  state_t            state,
  output logic              settled,
  output logic              active,
  output logic              match,
  output logic [1:0]        code,
  output op_t               op,
  output logic [DATA_W-1:0] s_data
);

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] s_code, l_code, sel_code;
  op_t        sel_op;
  logic [7:0] cnt;

  // Save outranks load whenever both request a slot.
  always_comb begin
    sel_code = l_code;
    sel_op   = OP_LOAD;
    if (s_code != NONE) begin
      sel_code = s_code;
      sel_op   = OP_SAVE;
    end
  end

  assign active  = (sel_code != NONE);
  assign match   = active && (sel_code == code) && (sel_op == op);
  assign settled = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_code <= NONE;
      l_code <= NONE;
      s_data <= '0;
      code   <= NONE;
      op     <= OP_SAVE;
      cnt    <= '0;
    end else begin
      s_code <= slot_code(save_signal);
      l_code <= slot_code(load_signal);
      s_data <= data_in;
      case (state)
        IDLE: if (active) begin
          code <= sel_code;
          op   <= sel_op;
          cnt  <= '0;
        end
        SETTLE: if (!settled) begin
          if (match) begin
            cnt <= cnt + 8'd1;
          end else if (active) begin
            code <= sel_code;
            op   <= sel_op;
            cnt  <= '0;
          end
        end
        HOLD: if (active && !match) begin
          code <= sel_code;
          op   <= sel_op;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/save_slot_store.sv
// Three-slot snapshot store: commits or returns a snapshot once a menu code has settled.
import save_slot_pkg::*;

// state  | meaning
// IDLE   | no request pending
// SETTLE | counting identical samples of the latched code
// SAVE   | write s_data into the latched slot
// LOAD   | copy the latched slot to sensor_output (or flag a miss)
// HOLD   | action done, waiting for the code to change or release
module save_slot_store #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DATA_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       save_signal,
  input  logic [31:0]       load_signal,
  input  logic [DATA_W-1:0] sensor_input_to_save,
  output logic [DATA_W-1:0] sensor_output,
  output logic [2:0]        slot_valid,
  output logic              save_done,
  output logic              load_valid,
  output logic              load_miss,
  output logic              busy
);

  state_t            state;
  logic              settled, active, match;
  logic [1:0]        code;
  op_t               op;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] slots [3];
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  code_settle #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .DATA_W        (DATA_W)
  ) u_code_settle (
    .clock       (clock),
    .reset       (reset),
    .save_signal (save_signal),
    .load_signal (load_signal),
    .data_in     (sensor_input_to_save),
    .state       (state),
    .settled     (settled),
    .active      (active),
    .match       (match),
    .code        (code),
    .op          (op),
    .s_data      (s_data)
  );

  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (code == 2'(i + 1)) begin
        rd_data  = slots[i];
        rd_valid = slot_valid[i];
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      slot_valid    <= '0;
      sensor_output <= '0;
      save_done     <= 1'b0;
      load_valid    <= 1'b0;
      load_miss     <= 1'b0;
      for (int i = 0; i < 3; i++) slots[i] <= '0;
    end else begin
      save_done  <= 1'b0;
      load_valid <= 1'b0;
      load_miss  <= 1'b0;
      case (state)
        IDLE: if (active) state <= SETTLE;
        SETTLE: begin
          // Once the count is reached the action fires even if the code just dropped.
          if (settled)      state <= (op == OP_SAVE) ? SAVE : LOAD;
          else if (!active) state <= IDLE;
        end
        SAVE: begin
          for (int i = 0; i < 3; i++) begin
            if (code == 2'(i + 1)) begin
              slots[i]      <= s_data;
              slot_valid[i] <= 1'b1;
            end
          end
          save_done <= 1'b1;
          state     <= HOLD;
        end
        LOAD: begin
          if (rd_valid) begin
            sensor_output <= rd_data;
            load_valid    <= 1'b1;
          end else begin
            load_miss <= 1'b1;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (!active)     state <= IDLE;
          else if (!match) state <= SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
